// File: rtl/ev20_ctrl_seq.sv
// ev20_ctrl_seq: fetch/decode/exec/mem sequencer driving the ev20 datapath; EV20_CTRL_CARRY_EN adds the carry flag and JC
module ev20_ctrl_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        if_req,
    output logic [9:0]  if_addr,
    input  logic        if_ack,
    input  logic [47:0] if_data,
    output logic [3:0]  aluc_in,
    output logic        cy_in,
    output logic [1:0]  shifter_sel,
    output logic [5:0]  sel_a_rb,
    output logic [5:0]  sel_b_rb,
    output logic [5:0]  c_sel_rb,
    output logic        y_x_kmx_sel,
    output logic [15:0] y_kmx_in,
    output logic        mr,
    output logic        mw,
    output logic [9:0]  mem_addr,
    input  logic        cy_out,
    output logic        halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;
    state_t state, state_n;
    logic [9:0] pc;
    logic [47:0] ir;
    logic [3:0] op;
    logic alu, ldst, flag, unused;
    assign op = ir[47:44];
    assign alu = op == 4'd1 || op == 4'd2;
    assign ldst = op == 4'd3 || op == 4'd4;
    assign if_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= '0;
            ir <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && if_ack) ir <= if_data;
            if (state == DECODE) pc <= pc + 10'd1;
            if (state == EXEC && (op == 4'd5 || (op == 4'd6 && flag))) pc <= ir[9:0];
        end
    end
`ifdef EV20_CTRL_CARRY_EN
    always_ff @(posedge clk) begin
        if (rst) flag <= 1'b0;
        else if (state == EXEC && alu) flag <= cy_out;
    end
    assign unused = ^ir[19:16];
`else
    // Without the carry option JC never branches and CY_OUT is ignored.
    assign flag = 1'b0;
    assign unused = ^{ir[19:16], cy_out};
`endif
    always_comb begin
        state_n = state;
        if_req = 1'b0;
        halted = 1'b0;
        aluc_in = '0;
        cy_in = 1'b0;
        shifter_sel = '0;
        sel_a_rb = '0;
        sel_b_rb = '0;
        c_sel_rb = '0;
        y_x_kmx_sel = 1'b0;
        y_kmx_in = '0;
        mr = 1'b0;
        mw = 1'b0;
        mem_addr = '0;
        case (state)
            IDLE: state_n = start ? FETCH : IDLE;
            FETCH: begin
                if_req = 1'b1;
                state_n = if_ack ? DECODE : FETCH;
            end
            DECODE: state_n = EXEC;
            EXEC: begin
                state_n = ldst ? MEM : op == 4'd7 ? HALT : FETCH;
                cy_in = flag;
                if (alu) begin
                    aluc_in = ir[43:40];
                    shifter_sel = ir[39:38];
                    c_sel_rb = ir[37:32];
                    sel_a_rb = ir[31:26];
                    sel_b_rb = ir[25:20];
                    y_x_kmx_sel = op == 4'd2;
                    y_kmx_in = op == 4'd2 ? ir[15:0] : '0;
                end
                if (ldst) begin
                    sel_a_rb = ir[31:26];
                    sel_b_rb = ir[25:20];
                    mem_addr = ir[9:0];
                end
            end
            MEM: begin
                state_n = FETCH;
                mem_addr = ir[9:0];
                mr = op == 4'd3;
                mw = op == 4'd4;
                c_sel_rb = op == 4'd3 ? ir[37:32] : '0;
                sel_b_rb = op == 4'd4 ? ir[25:20] : '0;
            end
            HALT: halted = 1'b1;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/ev20_ctrl_seq.md
EV20_CTRL_SEQ -- requirements
Module: ev20_ctrl_seq

Interface
REQ-001 SHALL have ports: CLK  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: RST  in  1  reset, synchronous, active-high.
REQ-003 START  in  1  leave IDLE and begin fetching at PC=0.
REQ-004 IF_REQ  out  1  instruction fetch request; IF_ADDR  out  10  program counter (PC).
REQ-005 IF_ACK  in  1  fetch complete; IF_DATA  in  48  instruction word, sampled when IF_REQ&IF_ACK.
REQ-006 Datapath drive, all outputs: ALUC_IN 4, CY_IN 1, Shifter_Sel 2, SEL_A_RB 6, SEL_B_RB 6, C_SEL_RB 6, Y_X_Kmx_Sel 1, Y_KMx_IN 16, MR 1, MW 1, MEM_ADDR 10.
REQ-007 CY_OUT  in  1  datapath carry out, sampled at end of EXEC.
REQ-008 HALTED  out  1  high while in HALT state.

Function
REQ-009 Word fields: [47:44] op, [43:40] aluc, [39:38] shift, [37:32] C, [31:26] A, [25:20] B, [15:0] K; [19:16] ignored.
REQ-010 Ops: 0 NOP, 1 ALU reg-reg, 2 ALU imm, 3 LOAD, 4 STORE, 5 JMP, 6 JC, 7 HALT; 8-15 SHALL execute as NOP.
REQ-011 States: IDLE, FETCH, DECODE, EXEC, MEM, HALT; IDLE->FETCH when START=1.
REQ-012 FETCH: IF_REQ=1, IF_ADDR=PC held stable until IF_ACK; on IF_ACK latch IF_DATA into IR, go DECODE; no timeout.
REQ-013 DECODE: one cycle; PC <= PC+1 mod 1024 (1023 wraps to 0); go EXEC.
REQ-014 EXEC (one cycle): ops 1/2 drive ALUC_IN=aluc, Shifter_Sel=shift, SEL_A_RB=A, SEL_B_RB=B, C_SEL_RB=C; op 2 also Y_X_Kmx_Sel=1, Y_KMx_IN=K; op1 Y_X_Kmx_Sel=0.
REQ-015 EXEC ops 3/4: SEL_A_RB=A, SEL_B_RB=B, MEM_ADDR=K[9:0]; next state MEM; all others next FETCH, or HALT for op 7.
REQ-016 MEM (one cycle): LOAD MR=1, C_SEL_RB=C, MEM_ADDR held; STORE MW=1, SEL_B_RB=B; MR and MW SHALL never be high together; next FETCH.
REQ-017 JMP: PC <= K[9:0] in EXEC, overriding the DECODE increment.
REQ-018 Outside EXEC/MEM all datapath outputs SHALL be 0; ALU ops latency FETCH-ack to write = 2 cycles.
REQ-019 HALT: absorbing; only RST exits; IF_REQ=0.
REQ-020 START ignored outside IDLE.

Reset
REQ-021 RST=1 at any edge, including mid-FETCH or MEM: state IDLE, PC=0, IR=0, carry flag=0, all outputs 0 next cycle; RST overrides START and IF_ACK.
REQ-022 IF_ACK arriving while RST=1 SHALL be discarded.

Configuration
REQ-023 Macro EV20_CTRL_CARRY_EN defined: carry flag register loaded from CY_OUT at end of EXEC for ops 1/2; CY_IN=flag during EXEC; JC sets PC<=K[9:0] iff flag=1.
REQ-024 Macro undefined: no flag register; CY_IN always 0; JC executes as NOP (PC increments only).

Verification
REQ-025 RST, START, IF_ACK immediate, word op1 aluc=3 A=2 B=5 C=7 -> EXEC cycle shows ALUC_IN=3, SEL_A_RB=2, SEL_B_RB=5, C_SEL_RB=7, Y_X_Kmx_Sel=0, outputs 0 next cycle, IF_ADDR=1.
REQ-026 op2 K=0xBEEF with IF_ACK delayed 3 cycles -> IF_REQ held 4 cycles, IF_ADDR constant, EXEC Y_KMx_IN=0xBEEF, Y_X_Kmx_Sel=1.
REQ-027 LOAD K=0x3A5, C=9 then STORE -> LOAD MEM cycle MR=1, MEM_ADDR=0x3A5, C_SEL_RB=9; STORE MEM cycle MW=1 only; never MR&MW.
REQ-028 JMP K=1023 then NOP -> next fetch IF_ADDR=1023, following fetch IF_ADDR=0.
REQ-029 With EV20_CTRL_CARRY_EN: op1 with CY_OUT=1, then JC K=0x40 -> next IF_ADDR=0x40 and CY_IN=1 on a following ALU op; without macro -> IF_ADDR=PC+1, CY_IN=0.
REQ-030 RST asserted during MEM of STORE -> MW=0 next cycle, IDLE, PC=0; HALT then START -> remains HALTED=1.
